// File: rtl/reg_wb_queue.sv
// Write-back queue feeding the register file's single write port: arbitrates
// load/ALU write-backs into an in-order FIFO, retires one per cycle, and offers decode bypass.
module reg_wb_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          alu_valid,
  input  logic [AW-1:0] alu_addr,
  input  logic [DW-1:0] alu_data,
  output logic          alu_ready,
  input  logic          mem_valid,
  input  logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] mem_data,
  output logic          mem_ready,
  output logic          wb_we,
  output logic [AW-1:0] wb_addr,
  output logic [DW-1:0] wb_data,
  input  logic [AW-1:0] rd_addr1,
  input  logic [AW-1:0] rd_addr2,
  output logic          byp_hit1,
  output logic          byp_hit2,
  output logic [DW-1:0] byp_data1,
  output logic [DW-1:0] byp_data2,
  output logic          full,
  output logic          empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0] addr_q [DEPTH];
  logic [DW-1:0] data_q [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;

  logic          mem_fire;
  logic          alu_fire;
  logic [AW-1:0] push_addr;
  logic [DW-1:0] push_data;
  logic          push;
  logic          pop;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  // Loads win arbitration; fullness looks only at the registered count.
  assign mem_ready = !rst && !full;
  assign alu_ready = !rst && !full && !mem_valid;
  assign mem_fire  = mem_valid && mem_ready;
  assign alu_fire  = alu_valid && alu_ready;

  assign push_addr = mem_fire ? mem_addr : alu_addr;
  assign push_data = mem_fire ? mem_data : alu_data;
  assign push      = (mem_fire || alu_fire) && (push_addr != '0);
  assign pop       = (count != '0);

  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[wr_ptr] <= push_addr;
      data_q[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      wb_we   <= 1'b0;
      wb_addr <= '0;
      wb_data <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        wb_we   <= 1'b1;
        wb_addr <= addr_q[rd_ptr];
        wb_data <= data_q[rd_ptr];
        rd_ptr  <= rd_ptr + PW'(1);
      end else begin
        wb_we <= 1'b0;
      end
      if (push && !pop) begin
        count <= count + CW'(1);
      end else if (!push && pop) begin
        count <= count - CW'(1);
      end
    end
  end

  logic [AW-1:0] ra    [2];
  logic [1:0]    hit;
  logic [DW-1:0] bdata [2];

  assign ra[0] = rd_addr1;
  assign ra[1] = rd_addr2;

  // Scan wb register then FIFO oldest to newest so the youngest match overwrites.
  always_comb begin
    hit      = '0;
    bdata[0] = '0;
    bdata[1] = '0;
    for (int p = 0; p < 2; p++) begin
      if (wb_we && wb_addr == ra[p]) begin
        hit[p]   = 1'b1;
        bdata[p] = wb_data;
      end
      for (int i = 0; i < DEPTH; i++) begin
        if (CW'(i) < count && addr_q[rd_ptr + PW'(i)] == ra[p]) begin
          hit[p]   = 1'b1;
          bdata[p] = data_q[rd_ptr + PW'(i)];
        end
      end
      if (ra[p] == '0) begin
        hit[p]   = 1'b0;
        bdata[p] = '0;
      end
    end
  end

  assign byp_hit1  = hit[0];
  assign byp_hit2  = hit[1];
  assign byp_data1 = bdata[0];
  assign byp_data2 = bdata[1];

endmodule

// File: tb/tb_reg_wb_queue.sv
// Bench for reg_wb_queue: constant vector table, hand-written reset sequence,
// then randomized traffic against a queue-based reference model.
module tb_reg_wb_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid, mem_valid;
  logic [4:0]  alu_addr, mem_addr, rd_addr1, rd_addr2;
  logic [31:0] alu_data, mem_data;
  logic        alu_ready, mem_ready, wb_we, byp_hit1, byp_hit2, full, empty;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data, byp_data1, byp_data2;

  int nChecks = 0;
  int nFails  = 0;

  always #5 clk = ~clk;

  reg_wb_queue #(.DEPTH(DEPTH), .AW(5), .DW(32)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_data(mem_data), .mem_ready(mem_ready),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .byp_hit1(byp_hit1), .byp_hit2(byp_hit2), .byp_data1(byp_data1), .byp_data2(byp_data2),
    .full(full), .empty(empty)
  );

  typedef struct {
    logic rst; logic mv; logic [4:0] ma; logic [31:0] md;
    logic av; logic [4:0] aa; logic [31:0] ad; logic [4:0] r1; logic [4:0] r2;
    logic chkByp; logic eAr; logic eMr; logic eH1; logic [31:0] eD1;
    logic eWe; logic [4:0] eWa; logic [31:0] eWd; logic eEmpty;
  } vec_t;

  typedef struct { logic [4:0] addr; logic [31:0] data; } ent_t;

  // Reference model: pending writes as a plain queue plus the write-port register.
  ent_t        mq[$];
  logic        mWe = 1'b0;
  logic [4:0]  mAddr = '0;
  logic [31:0] mData = '0;
  bit          modelOk = 0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    rst = v.rst;
    mem_valid = v.mv; mem_addr = v.ma; mem_data = v.md;
    alu_valid = v.av; alu_addr = v.aa; alu_data = v.ad;
    rd_addr1 = v.r1; rd_addr2 = v.r2;
  endtask

  task automatic updateModel();
    bit   fm, fa;
    ent_t e;
    if (rst) begin
      mq.delete();
      mWe = 0; mAddr = '0; mData = '0;
      modelOk = 1;
    end else begin
      fm = mem_valid && (mq.size() < DEPTH);
      fa = alu_valid && (mq.size() < DEPTH) && !mem_valid;
      if (mq.size() > 0) begin
        e = mq.pop_front();
        mWe = 1; mAddr = e.addr; mData = e.data;
      end else begin
        mWe = 0;
      end
      if (fm && mem_addr != 0) mq.push_back('{mem_addr, mem_data});
      else if (fa && alu_addr != 0) mq.push_back('{alu_addr, alu_data});
    end
  endtask

  function automatic void modelByp(input logic [4:0] ra, output logic hit, output logic [31:0] d);
    hit = 0; d = '0;
    if (ra != 0) begin
      for (int i = mq.size() - 1; i >= 0; i--) begin
        if (mq[i].addr == ra) begin
          hit = 1; d = mq[i].data;
          break;
        end
      end
      if (!hit && mWe && mAddr == ra) begin
        hit = 1; d = mData;
      end
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    updateModel();
  endtask

  task automatic idle(input logic r);
    rst = r; mem_valid = 0; alu_valid = 0;
    mem_addr = '0; alu_addr = '0; mem_data = '0; alu_data = '0;
  endtask

  vec_t vecs[16];

  initial begin
    logic        h;
    logic [31:0] d;
    logic        full0;

    vecs[0]  = '{1,0,0,0,      0,0,0,        0,0, 0, 0,0,0,0,        0,0,0,1};
    vecs[1]  = '{0,0,0,0,      1,5,'h1234,   5,0, 1, 1,1,0,0,        0,0,0,0};
    vecs[2]  = '{0,0,0,0,      0,0,0,        5,0, 1, 1,1,1,'h1234,   1,5,'h1234,1};
    vecs[3]  = '{0,0,0,0,      0,0,0,        5,0, 1, 1,1,1,'h1234,   0,5,'h1234,1};
    vecs[4]  = '{0,0,0,0,      0,0,0,        5,0, 1, 1,1,0,0,        0,5,'h1234,1};
    vecs[5]  = '{0,1,3,'hA,    1,4,'hB,      3,0, 1, 0,1,0,0,        0,5,'h1234,0};
    vecs[6]  = '{0,0,0,0,      1,4,'hB,      3,0, 1, 1,1,1,'hA,      1,3,'hA,0};
    vecs[7]  = '{0,0,0,0,      0,0,0,        3,0, 1, 1,1,1,'hA,      1,4,'hB,1};
    vecs[8]  = '{0,0,0,0,      0,0,0,        4,0, 1, 1,1,1,'hB,      0,4,'hB,1};
    vecs[9]  = '{0,0,0,0,      1,0,'hFFFF,   0,0, 1, 1,1,0,0,        0,4,'hB,1};
    vecs[10] = '{0,0,0,0,      0,0,0,        0,0, 1, 1,1,0,0,        0,4,'hB,1};
    vecs[11] = '{0,0,0,0,      1,7,'h11,     7,0, 1, 1,1,0,0,        0,4,'hB,0};
    vecs[12] = '{0,0,0,0,      1,7,'h22,     7,0, 1, 1,1,1,'h11,     1,7,'h11,0};
    vecs[13] = '{0,0,0,0,      0,0,0,        7,0, 1, 1,1,1,'h22,     1,7,'h22,1};
    vecs[14] = '{0,0,0,0,      0,0,0,        7,0, 1, 1,1,1,'h22,     0,7,'h22,1};
    vecs[15] = '{0,0,0,0,      0,0,0,        7,0, 1, 1,1,0,0,        0,7,'h22,1};

    $display("[TB] table phase");
    for (int i = 0; i < 16; i++) begin
      applyStimulus(vecs[i]);
      #1;
      checkOutput("alu_ready", alu_ready, vecs[i].eAr);
      checkOutput("mem_ready", mem_ready, vecs[i].eMr);
      if (vecs[i].chkByp) begin
        checkOutput("byp_hit1", byp_hit1, vecs[i].eH1);
        checkOutput("byp_data1", byp_data1, vecs[i].eD1);
        checkOutput("byp_hit2", byp_hit2, 0);
        checkOutput("byp_data2", byp_data2, 0);
        checkOutput("full", full, 0);
      end
      tick();
      checkOutput("wb_we", wb_we, vecs[i].eWe);
      checkOutput("wb_addr", wb_addr, vecs[i].eWa);
      checkOutput("wb_data", wb_data, vecs[i].eWd);
      checkOutput("empty", empty, vecs[i].eEmpty);
    end

    // Reset with an entry still queued: it must be dropped, then traffic resumes.
    $display("[TB] reset flush sequence");
    idle(0); alu_valid = 1; alu_addr = 9; alu_data = 32'h99; rd_addr1 = 9;
    tick();
    checkOutput("flush_pre_empty", empty, 0);
    idle(1); mem_valid = 1; mem_addr = 10; mem_data = 32'hAA;
    #1;
    checkOutput("rst_mem_ready", mem_ready, 0);
    checkOutput("rst_alu_ready", alu_ready, 0);
    tick();
    checkOutput("flush_we", wb_we, 0);
    checkOutput("flush_empty", empty, 1);
    checkOutput("flush_addr", wb_addr, 0);
    checkOutput("flush_byp_hit1", byp_hit1, 0);
    for (int i = 0; i < 2; i++) begin
      idle(0);
      tick();
      checkOutput("post_flush_we", wb_we, 0);
    end
    alu_valid = 1; alu_addr = 12; alu_data = 32'hC3; rd_addr1 = 12;
    tick();
    checkOutput("resume_empty", empty, 0);
    idle(0);
    #1;
    checkOutput("resume_byp_hit1", byp_hit1, 1);
    checkOutput("resume_byp_data1", byp_data1, 32'hC3);
    tick();
    checkOutput("resume_we", wb_we, 1);
    checkOutput("resume_addr", wb_addr, 12);
    checkOutput("resume_data", wb_data, 32'hC3);

    $display("[TB] random phase");
    for (int c = 0; c < 400; c++) begin
      rst       = ($urandom_range(0, 39) == 0);
      mem_valid = $urandom_range(0, 1) == 1;
      alu_valid = $urandom_range(0, 3) != 0;
      mem_addr  = 5'($urandom_range(0, 7));
      alu_addr  = 5'($urandom_range(0, 7));
      mem_data  = $urandom;
      alu_data  = $urandom;
      rd_addr1  = 5'($urandom_range(0, 7));
      rd_addr2  = 5'($urandom_range(0, 7));
      #1;
      if (modelOk) begin
        full0 = (mq.size() == DEPTH);
        checkOutput("rnd_mem_ready", mem_ready, !rst && !full0);
        checkOutput("rnd_alu_ready", alu_ready, !rst && !full0 && !mem_valid);
        modelByp(rd_addr1, h, d);
        checkOutput("rnd_byp_hit1", byp_hit1, h);
        checkOutput("rnd_byp_data1", byp_data1, d);
        modelByp(rd_addr2, h, d);
        checkOutput("rnd_byp_hit2", byp_hit2, h);
        checkOutput("rnd_byp_data2", byp_data2, d);
      end
      tick();
      checkOutput("rnd_wb_we", wb_we, mWe);
      checkOutput("rnd_wb_addr", wb_addr, mAddr);
      checkOutput("rnd_wb_data", wb_data, mData);
      checkOutput("rnd_empty", empty, mq.size() == 0);
      checkOutput("rnd_full", full, mq.size() == DEPTH);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/reg_wb_queue.md
# reg_wb_queue

Write-back queue for the CPU register file's single write port. It accepts write-back requests from the ALU and load paths through valid/ready handshakes and buffers them in a small in-order FIFO. It retires one entry per cycle onto the register file write port. It also exposes bypass lookups so the decode-stage read ports can see values that are queued but not yet written.

## Interface
Parameters:
- DEPTH, 4, FIFO entries (power of two, ≥2)
- AW, 5, register address width
- DW, 32, data width

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- alu_valid  in  1  ALU write-back request
- alu_addr  in  AW  ALU destination register
- alu_data  in  DW  ALU result
- alu_ready  out  1  ALU request accepted this cycle
- mem_valid  in  1  load write-back request
- mem_addr  in  AW  load destination register
- mem_data  in  DW  load data
- mem_ready  out  1  load request accepted this cycle
- wb_we  out  1  register file write enable (registered)
- wb_addr  out  AW  register file write address (registered)
- wb_data  out  DW  register file write data (registered)
- rd_addr1, rd_addr2  in  AW  decode read addresses
- byp_hit1, byp_hit2  out  1  pending write exists for rd_addrN
- byp_data1, byp_data2  out  DW  youngest pending value for rd_addrN
- full, empty  out  1  FIFO status

## Operation
- State: DEPTH-entry storage {addr, data}, write pointer, read pointer, count (width log2(DEPTH)+1). Pointers wrap modulo DEPTH.
- Arbitration: at most one enqueue per cycle. The load path has fixed priority over the ALU path.
  - mem_ready = !rst && !full.
  - alu_ready = !rst && !full && !mem_valid.
  - A transfer occurs when valid && ready in the same cycle.
- full = (count == DEPTH). full uses the registered count only: no enqueue into a full queue, even if a pop happens in the same cycle.
- Register 0: a request with addr == 0 still completes the handshake (ready asserted as above) but is discarded. It is not enqueued and count does not change.
- Dequeue: whenever count > 0 at a rising edge, the head entry is loaded into wb_we/wb_addr/wb_data with wb_we = 1, the read pointer advances, and count decrements. If count == 0, wb_we = 0 and wb_addr/wb_data hold their previous values.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- Bypass: byp_hitN = 1 when rd_addrN != 0 and it matches the addr of any valid FIFO entry, or wb_we && wb_addr == rd_addrN.
  - byp_dataN is taken from the youngest match, ordered from the newest FIFO entry down to the oldest, then the wb_* register.
  - When byp_hitN = 0, byp_dataN = 0.
  - Bypass is purely combinational from stored state. Same-cycle incoming requests are not visible.
- Order: writes retire strictly in acceptance order. Two queued writes to the same register both retire; the later one wins in the register file.

## Timing
- Reset (rst high at an edge): count = 0, pointers = 0, wb_we = 0, wb_addr = 0, wb_data = 0, empty = 1, full = 0. While rst is high, alu_ready = mem_ready = 0, and byp_hit* = 0 after the first reset edge.
- Reset mid-operation: all queued entries are dropped without being written. An accepted-but-unretired write is lost by design; the pipeline is flushed with it.
- Latency: a request accepted at edge N into an empty queue gives wb_we = 1 with its addr/data during cycle N+1, i.e. it is written to the register file at edge N+2.
- Throughput: one retire per cycle. Under continuous single-source input the queue never grows beyond 1 entry.
- Bypass is valid one cycle after acceptance (edge N) and stays valid until the cycle after wb_we drops for that entry.

## Test plan
- Reset then a single ALU request (addr 5, data 0x1234) → alu_ready=1; next cycle wb_we=1, wb_addr=5, wb_data=0x1234; following cycle wb_we=0, empty=1.
- Both valid in the same cycle (mem addr 3 = 0xA, alu addr 4 = 0xB) → mem accepted, alu_ready=0. ALU is accepted next cycle. Write order is 3 then 4.
- Fill: hold wb_we low externally is impossible, so drive DEPTH+2 back-to-back mixed requests while both sources are valid every cycle. Check full never overflows, every accepted entry retires exactly once, in order.
- Bypass: enqueue addr 7 = 0x11 then addr 7 = 0x22, with rd_addr1=7 → byp_hit1=1 and byp_data1=0x22 until the second write retires. rd_addr2=0 → byp_hit2=0 throughout.
- addr 0 request with data 0xFFFF → handshake completes, no wb_we pulse, count unchanged.
- Assert rst with 3 entries queued → next cycle wb_we=0, empty=1, no further writes. New request after rst release retires normally.
